// File: rtl/taximeter_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter for the taximeter display path.
// Saturates the input to DIGITS decimal digits and produces a leading-zero blank mask.
module taximeter_bin2bcd_seq #(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 5
) (
    input  logic                  clk_50MHz,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAXVAL    = WIDTH'(10 ** DIGITS - 1);
    localparam logic [CW-1:0]    CNT_LOAD  = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS - 1){1'b1}}, 1'b0};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    src_q, src_d;
    logic [BW-1:0]       work_q, work_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    // Double-dabble correction: any digit >= 5 gets +3 so the following shift carries correctly.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] w);
        logic [BW-1:0] res;
        res = w;
        for (int i = 0; i < DIGITS; i++) begin
            if (w[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = w[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = w[4*i +: 4];
            end
        end
        return res;
    endfunction

    // Digit i is blanked only when it and every more significant digit are zero; ones never blank.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] v);
        logic [DIGITS-1:0] m;
        logic              upper_zero;
        m          = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (v[4*i +: 4] == 4'd0);
            m[i]       = upper_zero;
        end
        return m;
    endfunction

    // Next-state and result computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        work_d     = work_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d      = (bin > MAXVAL) ? MAXVAL : bin;
                    ovf_pend_d = (bin > MAXVAL);
                    work_d     = '0;
                    cnt_d      = CNT_LOAD;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                {work_d, src_d} = {add3_digits(work_q), src_q} << 1;
                cnt_d           = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    bcd_d   = work_d;
                    ovf_d   = ovf_pend_q;
                    blank_d = blank_mask(work_d);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            src_q      <= '0;
            work_q     <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BLANK_RST;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            work_q     <= work_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy  = (state_q == ST_SHIFT);
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign blank = blank_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_taximeter_bin2bcd_seq.sv
// Self-checking bench for taximeter_bin2bcd_seq: directed steps plus random values
// checked against an arithmetic decimal model.
module tb_taximeter_bin2bcd_seq;

    logic        clk_50MHz = 1'b0;
    logic        rst_n     = 1'b1;
    logic        start     = 1'b0;
    logic [16:0] bin       = 17'd0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        ovf;

    int pass_cnt  = 0;
    int check_cnt = 0;

    taximeter_bin2bcd_seq dut (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .blank     (blank),
        .ovf       (ovf)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    function automatic int sat_val(input int v);
        return (v > 99999) ? 99999 : v;
    endfunction

    function automatic logic [19:0] model_bcd(input int v);
        logic [19:0] r;
        int s;
        s = sat_val(v);
        for (int d = 0; d < 5; d++) r[4*d +: 4] = 4'((s / (10 ** d)) % 10);
        return r;
    endfunction

    function automatic logic [4:0] model_blank(input int v);
        logic [4:0] m;
        int s;
        s = sat_val(v);
        m[0] = 1'b0;
        for (int i = 1; i < 5; i++) m[i] = (s < 10 ** i);
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        check_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    // Full conversion: checks latency, busy window, results and single-cycle done.
    task automatic convert(input int v);
        int k;
        bit busy_ok;
        start = 1'b1;
        bin   = 17'(v);
        tick();
        start = 1'b0;
        bin   = 17'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        busy_ok = 1'b1;
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        check("done_latency", 32'(k), 32'd17);
        check("busy_window", 32'(busy_ok), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("bcd", 32'(bcd), 32'(model_bcd(v)));
        check("blank", 32'(blank), 32'(model_blank(v)));
        check("ovf", 32'(ovf), 32'(v > 99999));
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int k;
        int dones;
        int last_done;
        logic [19:0] held_bcd;
        logic [4:0]  held_blank;
        int rv;

        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_blank", 32'(blank), 32'h1E);
        check("rst_ovf", 32'(ovf), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        convert(0);
        convert(12345);
        convert(37);
        convert(99999);
        convert(131071);
        convert(100000);

        // Starts and bin changes while busy must be ignored.
        start = 1'b1;
        bin   = 17'd500;
        tick();
        dones = 0;
        k     = 0;
        while (k < 40) begin
            start = 1'($urandom);
            bin   = 17'($urandom);
            if (k == 0) start = 1'b1;
            tick();
            k++;
            if (done) begin
                dones++;
                start = 1'b0;
                break;
            end
        end
        check("busy_start_latency", 32'(k), 32'd17);
        check("busy_start_bcd", 32'(bcd), 32'h00500);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        check("busy_start_single_done", 32'(dones), 32'd1);

        // Start held high: done every 18 cycles, outputs never glitch during SHIFT.
        start      = 1'b1;
        bin        = 17'd42;
        held_bcd   = model_bcd(500);
        held_blank = model_blank(500);
        dones      = 0;
        last_done  = 0;
        k          = 0;
        while (k < 80 && dones < 3) begin
            tick();
            k++;
            if (done) begin
                dones++;
                check("held_period", 32'(k - last_done), 32'd18);
                last_done  = k;
                held_bcd   = model_bcd(42);
                held_blank = model_blank(42);
                if (dones == 3) start = 1'b0;
            end
            check("held_bcd_stable", 32'(bcd), 32'(held_bcd));
            check("held_blank_stable", 32'(blank), 32'(held_blank));
        end
        check("held_done_count", 32'(dones), 32'd3);
        tick();

        for (int i = 0; i < 8; i++) begin
            rv = int'($urandom_range(0, 131071));
            convert(rv);
        end
        convert(9);
        convert(10);
        convert(100);

        // Reset in the middle of a conversion discards everything.
        convert(8888);
        start = 1'b1;
        bin   = 17'd1234;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_blank", 32'(blank), 32'h1E);
        check("abort_ovf", 32'(ovf), 32'd0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        convert(1234);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/taximeter_bin2bcd_seq.md
# taximeter_bin2bcd_seq

Sequential (double-dabble) binary-to-BCD converter between the taximeter pricing core and the seven-segment display driver. It takes a 17-bit count (price, distance or waiting time), saturates it to five decimal digits, and converts it over WIDTH clock cycles with a start/busy/done handshake. It also produces a leading-zero blank mask so the display can suppress leading zeros. Results are registered and held stable between conversions, so the display scan never sees intermediate values.

## Interface
Parameters:
- WIDTH, 17, binary input width; also the number of shift cycles per conversion.
- DIGITS, 5, number of BCD output digits; MAXVAL = 10^DIGITS − 1 = 99999.

Ports:
- clk_50MHz  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request conversion; sampled only in IDLE
- bin  input  WIDTH  binary value; sampled on the accepting edge only
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when new results are valid
- bcd  output  4*DIGITS  packed BCD result; [3:0] ones … [19:16] ten-thousands
- blank  output  DIGITS  bit i=1: digit i is a leading zero; bit 0 always 0
- ovf  output  1  last accepted bin exceeded MAXVAL (bcd saturated)

## Operation
- States: IDLE, SHIFT. busy = (state == SHIFT).
- IDLE + start=1 at an edge:
  - Latch src = min(bin, MAXVAL) and ovf_pending = (bin > MAXVAL).
  - Clear the BCD working register; load cnt = WIDTH; go to SHIFT.
- IDLE + start=0: hold all state.
- SHIFT, each edge, applied in this order:
  - Add 3 to every working BCD digit that is ≥ 5.
  - Shift {work, src} left by one bit.
  - Decrement cnt.
- When the shift is made with cnt == 1 (last shift), at that same edge:
  - bcd ← final working value.
  - ovf ← ovf_pending.
  - blank ← computed mask; done ← 1; state ← IDLE.
- done is high for exactly one cycle and is 0 at every other edge.
- start while busy is ignored; no queuing, no effect on the running conversion.
- bin changes after acceptance have no effect.
- Blank mask:
  - blank[i] = 1 iff digit i == 0 and all higher digits == 0, for i ≥ 1.
  - blank[0] = 0, so value 0 shows a single "0".
- bcd, blank and ovf hold their values until the next done. They do not change during SHIFT.
- Working-register width: 4*DIGITS bits. The saturated input never overflows it, so no carry out of the top digit is possible.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0, done=0, ovf=0.
  - bcd=0, blank = all ones except bit 0 (5'b11110).
  - Working registers cleared.
- Latency: start accepted at edge E0; busy=1 from E0 to E(WIDTH); done=1 and results valid in the cycle after E(WIDTH), i.e. 17 cycles after acceptance.
- Back-to-back: start held or asserted during the done cycle is accepted at the next edge (state is IDLE). Maximum throughput is one conversion per WIDTH+1 cycles.
- Reset mid-conversion:
  - Aborts immediately; no done pulse.
  - Outputs take their reset values; the previously held result is lost.
- start and rst_n asserted together: reset wins.

## Test plan
- Reset, then start with bin=0 → done exactly 17 cycles after acceptance; bcd=0x00000, blank=5'b11110, ovf=0; busy high for the 17 cycles before done.
- bin=12345 → bcd=0x12345, blank=5'b00000, ovf=0. Then bin=37 → bcd=0x00037, blank=5'b11100.
- bin=99999 → bcd=0x99999, ovf=0. Then bin=131071 (max) → bcd=0x99999, ovf=1. Then bin=100000 → bcd=0x99999, ovf=1.
- Start with bin=500, then pulse start with bin=777 and change bin every cycle while busy → single done; bcd=0x00500; the second start is ignored.
- start held high continuously with bin=42 → done pulses every 18 cycles; bcd stays 0x00042; bcd/blank never glitch during SHIFT.
- Convert 8888 (done seen), start bin=1234, assert rst_n=0 at cycle 8 of SHIFT → no done; bcd=0, blank=5'b11110, busy=0 immediately. After release, bin=1234 converts correctly to 0x01234.
